// File: rtl/rv32_pipe_pkg.sv
// Shared definitions for the RV32 pipeline front end: IF/ID bundle layout,
// the canonical NOP, and the fetch-stage state encoding.
package rv32_pipe_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            valid;
        logic            misaligned;
    } if_id_t;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register for a fetched word that decode could not take.
// Clear wins over load; drain simply empties the entry.
module if_skid_buffer
    import rv32_pipe_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            load_in,
    input  logic            drain_in,
    input  logic            clear_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [ILEN-1:0] instr_in,
    input  logic            mis_in,
    output logic [XLEN-1:0] pc_out,
    output logic [ILEN-1:0] instr_out,
    output logic            mis_out,
    output logic            full_out
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic            mis_q, mis_d;
    logic            full_q, full_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        mis_d   = mis_q;
        full_d  = full_q;
        if (clear_in) begin
            full_d = 1'b0;
        end else if (load_in) begin
            pc_d    = pc_in;
            instr_d = instr_in;
            mis_d   = mis_in;
            full_d  = 1'b1;
        end else if (drain_in) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            mis_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            mis_q   <= mis_d;
            full_q  <= full_d;
        end
    end

    assign pc_out    = pc_q;
    assign instr_out = instr_q;
    assign mis_out   = mis_q;
    assign full_out  = full_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the architectural PC, captures AHB instruction
// words into the IF/ID register, absorbs decode stalls and squashes wrong-path words.
module fetch_stage
    import rv32_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [XLEN-1:0] pc_mux_in,
    input  logic [ILEN-1:0] instr_in,
    input  logic            ahb_ready_in,
    input  logic            misaligned_instr_in,
    input  logic            stall_in,
    input  logic            flush_in,
    output logic [XLEN-1:0] pc_out,
    output logic            fetch_en_out,
    output logic [XLEN-1:0] if_pc_out,
    output logic [ILEN-1:0] if_instr_out,
    output logic            if_valid_out,
    output logic            if_misaligned_out
);

    localparam if_id_t IF_ID_RESET = '{pc: '0, instr: NOP_INSTR, valid: 1'b0, misaligned: 1'b0};

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          if_id_q, if_id_d;
    logic            drop_q, drop_d;

    logic            flush_eff;
    logic            accept;
    logic [ILEN-1:0] fetched_instr;
    logic            skid_load, skid_drain, skid_clear, skid_full;
    logic [XLEN-1:0] skid_pc;
    logic [ILEN-1:0] skid_instr;
    logic            skid_mis;

    // The boot cycle never redirects; everywhere else a flush beats a stall.
    assign flush_eff     = flush_in && (state_q != S_BOOT);
    assign accept        = (state_q == S_RUN) && ahb_ready_in && !drop_q;
    assign fetched_instr = misaligned_instr_in ? NOP_INSTR : instr_in;

    assign skid_load  = !flush_eff && accept && stall_in;
    assign skid_drain = !flush_eff && (state_q == S_HOLD) && !stall_in;
    assign skid_clear = flush_eff;

    if_skid_buffer u_skid (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load_in   (skid_load),
        .drain_in  (skid_drain),
        .clear_in  (skid_clear),
        .pc_in     (pc_q),
        .instr_in  (fetched_instr),
        .mis_in    (misaligned_instr_in),
        .pc_out    (skid_pc),
        .instr_out (skid_instr),
        .mis_out   (skid_mis),
        .full_out  (skid_full)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_BOOT;
            pc_q    <= BOOT_ADDRESS;
            if_id_q <= IF_ID_RESET;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (skid_load) state_d = S_HOLD;
            S_HOLD:  if (flush_eff || !stall_in) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
        drop_d  = drop_q;
        if (flush_eff) begin
            pc_d               = pc_mux_in;
            if_id_d.instr      = NOP_INSTR;
            if_id_d.valid      = 1'b0;
            if_id_d.misaligned = 1'b0;
            // A word still in flight belongs to the old path; only one can be outstanding.
            drop_d             = drop_q || !ahb_ready_in;
        end else if (state_q == S_HOLD) begin
            if (!stall_in) begin
                if_id_d = '{pc: skid_pc, instr: skid_instr, valid: skid_full,
                            misaligned: skid_mis};
            end
        end else if (state_q == S_RUN) begin
            if (accept) begin
                pc_d = pc_mux_in;
                if (!stall_in) begin
                    if_id_d = '{pc: pc_q, instr: fetched_instr, valid: 1'b1,
                                misaligned: misaligned_instr_in};
                end
            end else begin
                if (ahb_ready_in) drop_d = 1'b0;
                if (!stall_in) begin
                    if_id_d.instr      = NOP_INSTR;
                    if_id_d.valid      = 1'b0;
                    if_id_d.misaligned = 1'b0;
                end
            end
        end
    end

    always_comb begin
        fetch_en_out      = (state_q == S_RUN);
        pc_out            = pc_q;
        if_pc_out         = if_id_q.pc;
        if_instr_out      = if_id_q.instr;
        if_valid_out      = if_id_q.valid;
        if_misaligned_out = if_id_q.misaligned;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Downstream neighbour of pcmux. Holds the architectural PC register that pcmux reads as pc_in, and loads it from pcmux's pc_mux_out.
- Accepts instruction words returned on the AHB instruction bus and places them in the IF/ID pipeline register for decode.
- Handles decode back-pressure with a one-entry skid buffer, and squashes wrong-path fetches on branch/trap flush.

Parameters:
BOOT_ADDRESS, 32'h0000_0000, PC value after reset (must equal pcmux BOOT_ADDRESS)
NOP_INSTR, 32'h0000_0013, addi x0,x0,0 inserted on bubbles, flushes and misaligned fetches

Ports:
clk_in  input  1  single clock, rising edge
rst_in  input  1  reset, asynchronous, active-low (0 = reset)
pc_mux_in  input  32  next PC from pcmux pc_mux_out
instr_in  input  32  instruction data from AHB instruction port
ahb_ready_in  input  1  AHB HREADY; instr_in valid when 1
misaligned_instr_in  input  1  pcmux misaligned_instr_logic_out for the current fetch
stall_in  input  1  decode cannot accept a new instruction
flush_in  input  1  branch taken / trap / mret redirect; pc_mux_in holds the target
pc_out  output  32  current fetch PC, to pcmux pc_in
fetch_en_out  output  1  request a fetch this cycle
if_pc_out  output  32  IF/ID: PC of held instruction
if_instr_out  output  32  IF/ID: instruction
if_valid_out  output  1  IF/ID: instruction valid
if_misaligned_out  output  1  IF/ID: fetch was misaligned (exception to be raised downstream)

Behaviour:
- Reset (rst_in=0, asynchronous):
  - pc_out=BOOT_ADDRESS, if_pc_out=0, if_instr_out=NOP_INSTR, if_valid_out=0, if_misaligned_out=0.
  - Skid buffer empty, drop_pending=0, state=S_BOOT.
- States: S_BOOT, S_RUN, S_HOLD.
- S_BOOT: lasts exactly 1 cycle after reset release.
  - fetch_en_out=0; pc_out holds BOOT_ADDRESS; IF/ID stays invalid.
  - Next state is S_RUN.
- S_RUN: fetch_en_out=1. A fetch is "accepted" when ahb_ready_in=1 and drop_pending=0.
  - Accepted, stall_in=0: pc_out<=pc_mux_in; IF/ID<={pc_out, instr, 1, mis}; stay in S_RUN.
  - Accepted, stall_in=1: skid buffer<={pc_out, instr, mis}; pc_out<=pc_mux_in; IF/ID holds its value; go to S_HOLD.
  - ahb_ready_in=0: pc_out holds. If stall_in=0, IF/ID<=bubble (valid=0, instr=NOP_INSTR). If stall_in=1, IF/ID holds.
  - ahb_ready_in=1 and drop_pending=1: the returned word is discarded; drop_pending<=0; pc_out holds; IF/ID follows the ahb_ready_in=0 rule.
- Misaligned fetch (mis=1 at acceptance): instr is replaced by NOP_INSTR, if_misaligned_out=1, if_valid_out=1. The PC still advances via pc_mux_in.
- S_HOLD: fetch_en_out=0; pc_out holds; IF/ID holds while stall_in=1.
  - stall_in=0: IF/ID<=skid buffer (valid=1); buffer emptied; go to S_RUN.
  - Zero-bubble drain: the next fetch is issued in the following cycle.
- Flush (flush_in=1) has the highest priority after reset, in any state, and overrides stall_in:
  - pc_out<=pc_mux_in.
  - IF/ID<=bubble (valid=0, instr=NOP_INSTR, misaligned=0).
  - Skid buffer emptied; state<=S_RUN.
  - If ahb_ready_in=0 in the flush cycle, drop_pending<=1 so the in-flight wrong-path word is discarded when it returns.
- Flush in S_BOOT is ignored.
- A new flush while drop_pending=1 keeps drop_pending=1; only one word is ever outstanding.
- Width rules:
  - pc_out is 32-bit with no arithmetic in this block; PC+4 and wrap-around are done in pcmux.
  - 32'hFFFF_FFFC+4 arriving as pc_mux_in=0 is loaded unchanged.
- Reset asserted mid-operation (any state, buffer full, drop pending) clears everything to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package rv32_pipe_pkg: NOP_INSTR, state encodings S_BOOT/S_RUN/S_HOLD, IF/ID bundle field widths.
- BOOT_ADDRESS stays a parameter so it can match pcmux.
- One sub-module: if_skid_buffer (1-entry {pc, instr, mis} register with load/drain/clear and a full flag).
- PC register, FSM and IF/ID register stay in fetch_stage.

Test Plan:
- Reset with BOOT_ADDRESS=0, release rst_in: cycle 1 pc_out=0, fetch_en_out=0, if_valid_out=0; cycle 2 fetch_en_out=1.
- Straight-line: pc_mux_in=pc_out+4, ahb_ready_in=1, instr_in=32'h00500093 at PC 0 and 32'h00108113 at PC 4 -> IF/ID shows {0,00500093,1} then {4,00108113,1}; pc_out=8.
- Stall: stall_in=1 when instr 32'h00208193 at PC 8 returns -> IF/ID holds {4,...}, buffer captures PC 8, fetch_en_out=0. stall_in=0 -> IF/ID={8,00208193,1}, fetch resumes at 12.
- Wait states: ahb_ready_in=0 for 3 cycles -> pc_out constant, if_valid_out=0, if_instr_out=32'h00000013.
- Flush: flush_in=1, pc_mux_in=32'h00000100, ahb_ready_in=0 -> pc_out=0x100, IF/ID invalid. Next returned word (ahb_ready_in=1) is dropped; the word after it is tagged PC 0x100.
- Misaligned: misaligned_instr_in=1, pc_out=32'h00000102 -> if_misaligned_out=1, if_instr_out=32'h00000013, if_pc_out=0x102. Assert rst_in=0 mid-stall -> all outputs at reset values asynchronously.
